// File: rtl/multi_toggle_fsm.sv
// multi_toggle_fsm: CH independent two-state (A/B) toggle machines. Each channel
// flips only after its input has been low for HOLD consecutive edges, which also
// filters short glitches. Outputs are registered levels plus one-cycle flip pulses.
// Optional feature macro MULTI_TOGGLE_CNT_EN adds per-channel saturating toggle
// counters (tog_cnt) with a synchronous clear (cnt_clr).
`timescale 1ns/1ps

module multi_toggle_fsm #(
   parameter int CH      = 4,
   parameter int HOLD    = 3,
   parameter int RESET_B = 1,
   parameter int CNT_W   = 8
) (
   input  logic                clk,
   input  logic                areset_n,
   input  logic [CH-1:0]       in,
`ifdef MULTI_TOGGLE_CNT_EN
   input  logic                cnt_clr,
   output logic [CH*CNT_W-1:0] tog_cnt,
`endif
   output logic [CH-1:0]       out,
   output logic [CH-1:0]       flip
);

   // Run counter only needs to reach HOLD-1; keep at least one bit for HOLD=1.
   localparam int RW = ($clog2(HOLD + 1) < 1) ? 1 : $clog2(HOLD + 1);
   localparam logic [RW-1:0] RUN_LAST = RW'(HOLD - 1);

   typedef enum logic {
      ST_A = 1'b0,
      ST_B = 1'b1
   } state_t;

   localparam state_t RESET_ST = (RESET_B != 0) ? ST_B : ST_A;

   // Reject nonsensical parameter sets at elaboration time.
   if (CH < 1 || HOLD < 1 || CNT_W < 1) begin : g_param_check
      $error("multi_toggle_fsm: CH, HOLD and CNT_W must all be >= 1");
   end

   for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      state_t        state_q;
      logic [RW-1:0] run_q;
      logic          flip_q;

      // Per-channel Moore FSM: count the low run, flip state and pulse on its last edge.
      always_ff @(posedge clk or negedge areset_n) begin
         if (!areset_n) begin
            state_q <= RESET_ST;
            run_q   <= '0;
            flip_q  <= 1'b0;
         end else if (in[gi]) begin
            run_q   <= '0;
            flip_q  <= 1'b0;
         end else if (run_q < RUN_LAST) begin
            run_q   <= run_q + 1'b1;
            flip_q  <= 1'b0;
         end else begin
            state_q <= (state_q == ST_A) ? ST_B : ST_A;
            run_q   <= '0;
            flip_q  <= 1'b1;
         end
      end

      assign out[gi]  = (state_q == ST_B);
      assign flip[gi] = flip_q;

`ifdef MULTI_TOGGLE_CNT_EN
      localparam logic [CNT_W-1:0] CNT_MAX = '1;

      logic             toggle_d;
      logic [CNT_W-1:0] cnt_q;

      // Same condition that makes the FSM flip at this edge.
      assign toggle_d = !in[gi] && (run_q == RUN_LAST);

      // Saturating toggle counter; clear wins over a coincident increment.
      always_ff @(posedge clk or negedge areset_n) begin
         if (!areset_n) begin
            cnt_q <= '0;
         end else if (cnt_clr) begin
            cnt_q <= '0;
         end else if (toggle_d && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end

      assign tog_cnt[gi*CNT_W +: CNT_W] = cnt_q;
`endif
   end

endmodule

// File: tb/tb_multi_toggle_fsm.sv
// Scoreboard bench for multi_toggle_fsm: a 4-channel HOLD=3 instance (RESET_B=1,
// CNT_W=2) and a 1-channel HOLD=1 instance (RESET_B=0). Stimulus pushes the
// hand-computed expected outputs; a monitor pops and compares after each edge.
`timescale 1ns/1ps

module tb_multi_toggle_fsm;

   logic       clk = 1'b0;
   logic       areset_n = 1'b0;
   logic [3:0] in_a = 4'b1111;
   logic       in_b = 1'b1;
   logic       cnt_clr = 1'b0;
   logic [3:0] out_a, flip_a;
   logic       out_b, flip_b;
   logic [7:0] cnt_a;

   always #5 clk = ~clk;

   multi_toggle_fsm #(.CH(4), .HOLD(3), .RESET_B(1), .CNT_W(2)) dut_a (
      .clk      (clk),
      .areset_n (areset_n),
      .in       (in_a),
`ifdef MULTI_TOGGLE_CNT_EN
      .cnt_clr  (cnt_clr),
      .tog_cnt  (cnt_a),
`endif
      .out      (out_a),
      .flip     (flip_a)
   );

   multi_toggle_fsm #(.CH(1), .HOLD(1), .RESET_B(0), .CNT_W(2)) dut_b (
      .clk      (clk),
      .areset_n (areset_n),
      .in       (in_b),
`ifdef MULTI_TOGGLE_CNT_EN
      .cnt_clr  (1'b0),
      .tog_cnt  (),
`endif
      .out      (out_b),
      .flip     (flip_b)
   );

`ifndef MULTI_TOGGLE_CNT_EN
   assign cnt_a = 8'h00;
`endif

   typedef struct {
      string      nm;
      logic [3:0] o;
      logic [3:0] f;
      logic       bo;
      logic       bf;
      logic [7:0] c;
   } exp_t;

   exp_t q[$];
   event chk_ev;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Monitor: after every rising edge (or an explicit async check) pop and compare.
   initial begin
      exp_t e;
      logic bad;
      forever begin
         @(posedge clk or chk_ev);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_tests++;
            bad = (out_a !== e.o) || (flip_a !== e.f) || (out_b !== e.bo) || (flip_b !== e.bf);
`ifdef MULTI_TOGGLE_CNT_EN
            bad = bad || (cnt_a !== e.c);
`endif
            if (bad) begin
               n_fail++;
               $display("FAIL %s: got out=%b flip=%b bout=%b bflip=%b cnt=%h, want out=%b flip=%b bout=%b bflip=%b cnt=%h",
                        e.nm, out_a, flip_a, out_b, flip_b, cnt_a, e.o, e.f, e.bo, e.bf, e.c);
            end else begin
               $display("[TB] %s: out=%b flip=%b bout=%b bflip=%b cnt=%h ok",
                        e.nm, out_a, flip_a, out_b, flip_b, cnt_a);
            end
         end
      end
   end

   function automatic exp_t mk(string nm, logic [3:0] o, logic [3:0] f, logic bo, logic bf, logic [7:0] c);
      exp_t e;
      e.nm = nm; e.o = o; e.f = f; e.bo = bo; e.bf = bf; e.c = c;
      return e;
   endfunction

   // One clocked transaction: drive inputs at the falling edge, expect result after next rise.
   task automatic step(input string nm, input logic [3:0] a, input logic b, input logic clr,
                       input logic [3:0] eo, input logic [3:0] ef, input logic ebo, input logic ebf,
                       input logic [7:0] ec);
      @(negedge clk);
      in_a    = a;
      in_b    = b;
      cnt_clr = clr;
      q.push_back(mk(nm, eo, ef, ebo, ebf, ec));
   endtask

   // Three low edges on the A instance: two holds, then a toggle on the third.
   task automatic run3(input string nm, input logic [3:0] a, input logic [3:0] o_before,
                       input logic [3:0] o_after, input logic [3:0] f, input logic [7:0] c_before,
                       input logic [7:0] c_after);
      step({nm, "_e1"}, a, 1'b1, 1'b0, o_before, 4'b0000, 1'b0, 1'b0, c_before);
      step({nm, "_e2"}, a, 1'b1, 1'b0, o_before, 4'b0000, 1'b0, 1'b0, c_before);
      step({nm, "_e3"}, a, 1'b1, 1'b0, o_after,  f,       1'b0, 1'b0, c_after);
   endtask

   // Asynchronous reset check in the middle of a low phase of the clock.
   task automatic async_reset_check(input string nm);
      @(negedge clk);
      #2;
      areset_n = 1'b0;
      q.push_back(mk(nm, 4'b1111, 4'b0000, 1'b0, 1'b0, 8'h00));
      ->chk_ev;
      #1;
   endtask

   initial begin
      // Power-on reset state, checked without a clock edge.
      repeat (2) @(posedge clk);
      async_reset_check("reset_state");
      in_a = 4'b1111; in_b = 1'b1;
      @(negedge clk);
      areset_n = 1'b1;

      // Partial run, then reset mid-run; B toggles so the async clear is visible.
      step("pre_rst_e1", 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 8'h00);
      step("pre_rst_e2", 4'b0000, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 8'h00);
      async_reset_check("mid_run_reset");
      in_a = 4'b1111; in_b = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      areset_n = 1'b1;

      // After release the run starts from zero: toggle only on the 3rd low edge.
      run3("post_rst", 4'b0000, 4'b1111, 4'b0000, 4'b1111, 8'h00, 8'h55);
      step("post_rst_hold", 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h55);

      // Single-channel debounce on channel 0.
      run3("ch0_deb", 4'b1110, 4'b0000, 4'b0001, 4'b0001, 8'h55, 8'h56);
      step("ch0_hold", 4'b1111, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'h56);

      // Run restart on channel 1: 0,0,1,0,0 never toggles.
      step("restart_e1", 4'b1101, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'h56);
      step("restart_e2", 4'b1101, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'h56);
      step("restart_e3", 4'b1111, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'h56);
      step("restart_e4", 4'b1101, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'h56);
      step("restart_e5", 4'b1101, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'h56);
      step("restart_e6", 4'b1111, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'h56);

      // Continuous low on channel 2 for 9 edges: toggles at 3, 6, 9; counter saturates.
      run3("cont_t1", 4'b1011, 4'b0001, 4'b0101, 4'b0100, 8'h56, 8'h66);
      run3("cont_t2", 4'b1011, 4'b0101, 4'b0001, 4'b0100, 8'h66, 8'h76);
      run3("cont_t3", 4'b1011, 4'b0001, 4'b0101, 4'b0100, 8'h76, 8'h76);
      step("cont_hold", 4'b1111, 1'b1, 1'b0, 4'b0101, 4'b0000, 1'b0, 1'b0, 8'h76);

      // HOLD=1 instance: toggles every low edge with flip held high, then holds.
      step("h1_e1", 4'b1111, 1'b0, 1'b0, 4'b0101, 4'b0000, 1'b1, 1'b1, 8'h76);
      step("h1_e2", 4'b1111, 1'b0, 1'b0, 4'b0101, 4'b0000, 1'b0, 1'b1, 8'h76);
      step("h1_e3", 4'b1111, 1'b0, 1'b0, 4'b0101, 4'b0000, 1'b1, 1'b1, 8'h76);
      step("h1_e4", 4'b1111, 1'b0, 1'b0, 4'b0101, 4'b0000, 1'b0, 1'b1, 8'h76);
      step("h1_hold1", 4'b1111, 1'b1, 1'b0, 4'b0101, 4'b0000, 1'b0, 1'b0, 8'h76);
      step("h1_hold2", 4'b1111, 1'b1, 1'b0, 4'b0101, 4'b0000, 1'b0, 1'b0, 8'h76);

      // Channel 3 toggles 2..5: counter (2 bits) reaches 3 and holds.
      run3("ch3_t2", 4'b0111, 4'b0101, 4'b1101, 4'b1000, 8'h76, 8'hB6);
      run3("ch3_t3", 4'b0111, 4'b1101, 4'b0101, 4'b1000, 8'hB6, 8'hF6);
      run3("ch3_t4", 4'b0111, 4'b0101, 4'b1101, 4'b1000, 8'hF6, 8'hF6);
      run3("ch3_t5", 4'b0111, 4'b1101, 4'b0101, 4'b1000, 8'hF6, 8'hF6);

      // Sixth toggle with a coincident clear: clear wins, the state still flips.
      step("ch3_t6_e1", 4'b0111, 1'b1, 1'b0, 4'b0101, 4'b0000, 1'b0, 1'b0, 8'hF6);
      step("ch3_t6_e2", 4'b0111, 1'b1, 1'b0, 4'b0101, 4'b0000, 1'b0, 1'b0, 8'hF6);
      step("ch3_t6_clr", 4'b0111, 1'b1, 1'b1, 4'b1101, 4'b1000, 1'b0, 1'b0, 8'h00);
      step("after_clr", 4'b1111, 1'b1, 1'b0, 4'b1101, 4'b0000, 1'b0, 1'b0, 8'h00);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #2;
      if (q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expected transactions left, want 0", q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
